// File: rtl/gray_decode_monitor_if.sv
// Bus between a Gray-count source and gray_decode_monitor.
// Optional sticky-error signals exist only when GRAY_DEC_STICKY_ERR_EN is defined.
interface gray_decode_monitor_if #(
    parameter int N     = 4,
    parameter int ERR_W = 8
);
    logic             sample_en;
    logic [N-1:0]     gray_in;
    logic [N-1:0]     bin_out;
    logic             bin_valid;
    logic             dir_up;
    logic             wrap_pulse;
    logic             step_err;
    logic [ERR_W-1:0] err_count;
`ifdef GRAY_DEC_STICKY_ERR_EN
    logic             err_clr;
    logic             err_sticky;

    modport master (
        output sample_en, gray_in, err_clr,
        input  bin_out, bin_valid, dir_up, wrap_pulse, step_err, err_count, err_sticky
    );
    modport slave (
        input  sample_en, gray_in, err_clr,
        output bin_out, bin_valid, dir_up, wrap_pulse, step_err, err_count, err_sticky
    );
`else
    modport master (
        output sample_en, gray_in,
        input  bin_out, bin_valid, dir_up, wrap_pulse, step_err, err_count
    );
    modport slave (
        input  sample_en, gray_in,
        output bin_out, bin_valid, dir_up, wrap_pulse, step_err, err_count
    );
`endif
endinterface

// File: rtl/gray_decode_monitor.sv
// Samples a Gray count, decodes it over two stages and checks each value is a legal +/-1 step.
// Optional feature macro: GRAY_DEC_STICKY_ERR_EN (adds err_clr / err_sticky).
module gray_decode_monitor #(
    parameter int N     = 4,
    parameter int ERR_W = 8
) (
    input logic                 clk,
    input logic                 rst,
    gray_decode_monitor_if.slave bus
);

    typedef enum logic [1:0] {
        INIT   = 2'd0,
        TRACK  = 2'd1,
        RESYNC = 2'd2
    } state_t;

    state_t           state;
    logic [N-1:0]     g_q;
    logic             v_q;
    logic [N-1:0]     bin_q;
    logic             valid_q;
    logic             dir_q;
    logic             wrap_q;
    logic             err_q;
    logic [ERR_W-1:0] cnt_q;
    logic [N-1:0]     bin_d;
    logic [N-1:0]     delta;
    logic             step_up;
    logic             step_dn;
    logic             step_zero;
    logic [ERR_W-1:0] cnt_inc;

    // Running XOR from the MSB down; a scalar accumulator avoids a self-referencing vector.
    always_comb begin
        logic acc;
        acc   = 1'b0;
        bin_d = '0;
        for (int i = N - 1; i >= 0; i--) begin
            acc      = acc ^ g_q[i];
            bin_d[i] = acc;
        end
    end

    // bin_q always holds the previous decoded sample, so it doubles as the step reference.
    assign delta     = bin_d - bin_q;
    assign step_zero = (delta == '0);
    assign step_up   = (delta == N'(1));
    assign step_dn   = (delta == '1);
    assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + ERR_W'(1);

`ifdef GRAY_DEC_STICKY_ERR_EN
    logic sticky_q;
`endif

    // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= INIT;
            g_q     <= '0;
            v_q     <= 1'b0;
            bin_q   <= '0;
            valid_q <= 1'b0;
            dir_q   <= 1'b0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
`ifdef GRAY_DEC_STICKY_ERR_EN
            sticky_q <= 1'b0;
`endif
        end else begin
            v_q     <= bus.sample_en;
            valid_q <= v_q;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
            if (bus.sample_en) begin
                g_q <= bus.gray_in;
            end
`ifdef GRAY_DEC_STICKY_ERR_EN
            if (bus.err_clr) begin
                cnt_q    <= '0;
                sticky_q <= 1'b0;
            end
`endif
            if (v_q) begin
                bin_q <= bin_d;
                case (state)
                    INIT, RESYNC: state <= TRACK;
                    TRACK: begin
                        if (step_up) begin
                            dir_q  <= 1'b1;
                            wrap_q <= (bin_q == '1);
                        end else if (step_dn) begin
                            dir_q  <= 1'b0;
                            wrap_q <= (bin_q == '0);
                        end else if (!step_zero) begin
                            err_q <= 1'b1;
                            state <= RESYNC;
`ifdef GRAY_DEC_STICKY_ERR_EN
                            // A simultaneous clear loses to the new error.
                            sticky_q <= 1'b1;
                            cnt_q    <= bus.err_clr ? ERR_W'(1) : cnt_inc;
`else
                            cnt_q <= cnt_inc;
`endif
                        end
                    end
                    default: state <= INIT;
                endcase
            end
        end
    end

    assign bus.bin_out    = bin_q;
    assign bus.bin_valid  = valid_q;
    assign bus.dir_up     = dir_q;
    assign bus.wrap_pulse = wrap_q;
    assign bus.step_err   = err_q;
    assign bus.err_count  = cnt_q;
`ifdef GRAY_DEC_STICKY_ERR_EN
    assign bus.err_sticky = sticky_q;
`endif

endmodule

// File: tb/tb_gray_decode_monitor.sv
// Directed bench for gray_decode_monitor: up/down counting, jumps, saturation, gating, reset.
module tb_gray_decode_monitor;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    gray_decode_monitor_if #(.N(4), .ERR_W(8)) dif ();
    gray_decode_monitor_if #(.N(4), .ERR_W(2)) sif ();

    assign sif.sample_en = dif.sample_en;
    assign sif.gray_in   = dif.gray_in;

    gray_decode_monitor #(.N(4), .ERR_W(8)) dut (.clk(clk), .rst(rst), .bus(dif));
    gray_decode_monitor #(.N(4), .ERR_W(2)) dut_sat (.clk(clk), .rst(rst), .bus(sif));

    // Gray code of 0..15, written out by hand.
    logic [3:0] gray_tab [16] = '{
        4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
        4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000
    };

    // Saturation stream: 0 then six illegal 0<->4 jumps, each followed by a repeat.
    logic [3:0] sat_seq [13] = '{
        4'b0000, 4'b0110, 4'b0110, 4'b0000, 4'b0000, 4'b0110, 4'b0110,
        4'b0000, 4'b0000, 4'b0110, 4'b0110, 4'b0000, 4'b0000
    };
    logic [3:0] sat_bin  [13] = '{0, 4, 4, 0, 0, 4, 4, 0, 0, 4, 4, 0, 0};
    logic       sat_err  [13] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0};
    int         sat_cnt8 [13] = '{0, 1, 1, 2, 2, 3, 3, 4, 4, 5, 5, 6, 6};
    int         sat_cnt2 [13] = '{0, 1, 1, 2, 2, 3, 3, 3, 3, 3, 3, 3, 3};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input logic en, input logic [3:0] g);
        @(negedge clk);
        dif.sample_en = en;
        dif.gray_in   = g;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst           = 1'b1;
        dif.sample_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        dif.sample_en = 1'b0;
        dif.gray_in   = 4'b0000;

        // Reset state
        do_reset();
        check("rst bin_out",   dif.bin_out,    0);
        check("rst bin_valid", dif.bin_valid,  0);
        check("rst dir_up",    dif.dir_up,     0);
        check("rst wrap",      dif.wrap_pulse, 0);
        check("rst step_err",  dif.step_err,   0);
        check("rst err_count", dif.err_count,  0);

        // Up count 0..15 then wrap to 0
        tick(1'b1, gray_tab[0]);
        for (int i = 1; i <= 16; i++) begin
            tick(1'b1, gray_tab[i % 16]);
            check("up bin_out",  dif.bin_out,    i - 1);
            check("up valid",    dif.bin_valid,  1);
            check("up dir_up",   dif.dir_up,     (i == 1) ? 0 : 1);
            check("up wrap",     dif.wrap_pulse, 0);
            check("up step_err", dif.step_err,   0);
        end
        tick(1'b0, 4'b0000);
        check("up wrap bin",   dif.bin_out,    0);
        check("up wrap valid", dif.bin_valid,  1);
        check("up wrap pulse", dif.wrap_pulse, 1);
        check("up wrap dir",   dif.dir_up,     1);
        tick(1'b0, 4'b0000);
        check("up idle valid", dif.bin_valid,  0);
        check("up idle wrap",  dif.wrap_pulse, 0);
        check("up idle errs",  dif.err_count,  0);

        // Down count 2,1,0,15
        do_reset();
        tick(1'b1, 4'b0011);
        tick(1'b1, 4'b0001);
        check("dn bin 2",    dif.bin_out, 2);
        tick(1'b1, 4'b0000);
        check("dn bin 1",    dif.bin_out, 1);
        check("dn dir 1",    dif.dir_up,  0);
        tick(1'b1, 4'b1000);
        check("dn bin 0",    dif.bin_out, 0);
        check("dn wrap 0",   dif.wrap_pulse, 0);
        tick(1'b0, 4'b0000);
        check("dn bin 15",   dif.bin_out,    15);
        check("dn wrap 15",  dif.wrap_pulse, 1);
        check("dn dir 15",   dif.dir_up,     0);
        check("dn step_err", dif.step_err,   0);

        // Jump 1 -> 4, resync on 5, legal step to 6
        do_reset();
        tick(1'b1, 4'b0001);
        tick(1'b1, 4'b0110);
        check("jmp bin 1",  dif.bin_out,  1);
        check("jmp err 1",  dif.step_err, 0);
        tick(1'b1, 4'b0111);
        check("jmp bin 4",  dif.bin_out,   4);
        check("jmp err 4",  dif.step_err,  1);
        check("jmp cnt 4",  dif.err_count, 1);
        check("jmp wrap 4", dif.wrap_pulse, 0);
        tick(1'b1, 4'b0101);
        check("jmp bin 5",  dif.bin_out,   5);
        check("jmp err 5",  dif.step_err,  0);
        check("jmp cnt 5",  dif.err_count, 1);
        check("jmp dir 5",  dif.dir_up,    0);
        tick(1'b0, 4'b0000);
        check("jmp bin 6",  dif.bin_out,   6);
        check("jmp err 6",  dif.step_err,  0);
        check("jmp dir 6",  dif.dir_up,    1);
        check("jmp cnt 6",  dif.err_count, 1);

        // Gating: gray_in toggles with sample_en low
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 4'($urandom_range(0, 15)));
            check("gate valid", dif.bin_valid,  0);
            check("gate bin",   dif.bin_out,    6);
            check("gate dir",   dif.dir_up,     1);
            check("gate wrap",  dif.wrap_pulse, 0);
            check("gate err",   dif.step_err,   0);
            check("gate cnt",   dif.err_count,  1);
        end

        // Mid-stream reset discards the in-flight sample
        tick(1'b1, 4'b0011);
        @(negedge clk);
        rst           = 1'b1;
        dif.sample_en = 1'b0;
        @(posedge clk);
        #1;
        check("mid rst valid", dif.bin_valid, 0);
        check("mid rst bin",   dif.bin_out,   0);
        check("mid rst cnt",   dif.err_count, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("mid post valid", dif.bin_valid, 0);
        tick(1'b1, 4'b1000);
        tick(1'b0, 4'b0000);
        check("mid init bin",   dif.bin_out,    15);
        check("mid init valid", dif.bin_valid,  1);
        check("mid init err",   dif.step_err,   0);
        check("mid init wrap",  dif.wrap_pulse, 0);

        // Saturation on the ERR_W=2 instance, full count on the ERR_W=8 one
        do_reset();
        tick(1'b1, sat_seq[0]);
        for (int j = 1; j <= 13; j++) begin
            tick((j <= 12) ? 1'b1 : 1'b0, (j <= 12) ? sat_seq[j % 13] : 4'b0000);
            check("sat bin",       sif.bin_out,   sat_bin[j - 1]);
            check("sat valid",     sif.bin_valid, 1);
            check("sat step_err",  sif.step_err,  sat_err[j - 1]);
            check("sat cnt w2",    sif.err_count, sat_cnt2[j - 1]);
            check("sat cnt w8",    dif.err_count, sat_cnt8[j - 1]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
